// File: rtl/dmem_access_unit_pkg.sv
// rtl/dmem_access_unit_pkg.sv - DMType, cause codes and FSM encodings for the data-memory access unit
package dmem_access_unit_pkg;

    localparam logic [2:0] dm_word           = 3'b000;
    localparam logic [2:0] dm_half           = 3'b001;
    localparam logic [2:0] dm_half_unsigned  = 3'b010;
    localparam logic [2:0] dm_byte           = 3'b011;
    localparam logic [2:0] dm_byte_unsigned  = 3'b100;

    localparam logic [7:0] cause_ld_misalign = 8'd4;
    localparam logic [7:0] cause_ld_fault    = 8'd5;
    localparam logic [7:0] cause_st_misalign = 8'd6;
    localparam logic [7:0] cause_st_fault    = 8'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    // Codes outside the shared table fall back to word accesses.
    function automatic size_t dm_size(input logic [2:0] dmtype);
        case (dmtype)
            dm_half, dm_half_unsigned: return SZ_HALF;
            dm_byte, dm_byte_unsigned: return SZ_BYTE;
            default:                   return SZ_WORD;
        endcase
    endfunction

    function automatic logic dm_unsigned(input logic [2:0] dmtype);
        return (dmtype == dm_half_unsigned) || (dmtype == dm_byte_unsigned);
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] dmtype, input logic [1:0] addr_lo);
        case (dm_size(dmtype))
            SZ_HALF: return addr_lo[0];
            SZ_BYTE: return 1'b0;
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - store byte-enable/lane replication and load lane extraction
import dmem_access_unit_pkg::*;

module dmem_lane_fmt (
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dmtype,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  store_we,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = load_word[{addr_lo, 3'b000} +: 8];
    assign half_lane = load_word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        store_we   = 4'b1111;
        store_word = store_data;
        load_data  = load_word;
        case (dm_size(dmtype))
            SZ_BYTE: begin
                store_we   = 4'b0001 << addr_lo;
                store_word = {4{store_data[7:0]}};
                load_data  = dm_unsigned(dmtype) ? {24'b0, byte_lane}
                                                 : {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                store_we   = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = dm_unsigned(dmtype) ? {16'b0, half_lane}
                                                 : {{16{half_lane[15]}}, half_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - MEM-stage load/store sequencer with wait-state stall, misalign and timeout faults
import dmem_access_unit_pkg::*;

module dmem_access_unit #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_dmtype,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              exc_valid,
    output logic [7:0]        exc_cause,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ready
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, next_state;
    logic [7:0]  wait_cnt;
    logic        req_wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  dmtype_q;
    logic        aborted_q;

    logic        req, misaligned, issue, timed_out, in_idle;
    logic        fmt_store;
    logic [31:0] fmt_addr, fmt_wdata;
    logic [2:0]  fmt_dmtype;
    logic [3:0]  store_we;
    logic [31:0] store_word, load_data;
    logic        unused_addr_hi;

    assign req        = req_rd | req_wr;
    assign misaligned = dm_misaligned(req_dmtype, req_addr[1:0]);
    assign in_idle    = (state == ST_IDLE);
    assign issue      = in_idle && req && !misaligned;
    assign timed_out  = (state == ST_WAIT) && !ram_ready && (wait_cnt == TIMEOUT_CNT);

    // The issue cycle drives the RAM straight from the request; later cycles replay the latched copy.
    assign fmt_store  = in_idle ? req_wr     : req_wr_q;
    assign fmt_addr   = in_idle ? req_addr   : addr_q;
    assign fmt_wdata  = in_idle ? req_wdata  : wdata_q;
    assign fmt_dmtype = in_idle ? req_dmtype : dmtype_q;
    assign unused_addr_hi = ^fmt_addr[31:ADDR_W+2];

    dmem_lane_fmt u_lane_fmt (
        .addr_lo    (fmt_addr[1:0]),
        .dmtype     (fmt_dmtype),
        .store_data (fmt_wdata),
        .load_word  (ram_rdata),
        .store_we   (store_we),
        .store_word (store_word),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (issue) next_state = ST_WAIT;
            ST_WAIT: if (ram_ready || timed_out) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= 8'd0;
            req_wr_q  <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            dmtype_q  <= dm_word;
            aborted_q <= 1'b0;
            rsp_rdata <= 32'd0;
            exc_cause <= 8'd0;
        end else begin
            if (issue) begin
                wait_cnt  <= 8'd0;
                req_wr_q  <= req_wr;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                dmtype_q  <= req_dmtype;
                aborted_q <= 1'b0;
            end
            if (in_idle && req && misaligned)
                exc_cause <= req_wr ? cause_st_misalign : cause_ld_misalign;
            if (state == ST_WAIT && !ram_ready && !timed_out)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == ST_WAIT && ram_ready && !req_wr_q)
                rsp_rdata <= load_data;
            if (timed_out) begin
                aborted_q <= 1'b1;
                exc_cause <= req_wr_q ? cause_st_fault : cause_ld_fault;
            end
        end
    end

    // Outputs are forced low while reset is held so an in-flight RAM request dies immediately.
    always_comb begin
        stall     = 1'b0;
        rsp_valid = 1'b0;
        exc_valid = 1'b0;
        ram_en    = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (misaligned) begin
                            exc_valid = 1'b1;
                        end else begin
                            ram_en = 1'b1;
                            stall  = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    ram_en    = 1'b1;
                    stall     = 1'b1;
                    exc_valid = timed_out;
                end
                ST_DONE: rsp_valid = !aborted_q;
                default: ;
            endcase
        end
        ram_we    = (ram_en && fmt_store) ? store_we : 4'b0000;
        ram_addr  = ram_en ? fmt_addr[ADDR_W+1:2] : '0;
        ram_wdata = ram_en ? store_word : 32'd0;
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - scoreboard bench with a behavioural load/store reference model
module tb_dmem_access_unit;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_dmtype;
    logic        stall, rsp_valid, exc_valid, ram_en, ram_ready;
    logic [31:0] rsp_rdata, ram_wdata, ram_rdata;
    logic [7:0]  exc_cause;
    logic [3:0]  ram_we;
    logic [ADDR_W-1:0] ram_addr;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_dmtype(req_dmtype),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .exc_valid(exc_valid), .exc_cause(exc_cause),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    typedef struct {
        bit          is_exc;
        logic [31:0] rdata;
        logic [7:0]  cause;
    } rsp_t;

    typedef struct {
        bit          is_store;
        logic [3:0]  we;
        logic [ADDR_W-1:0] addr;
        logic [31:0] wdata;
        int          en_cycles;
    } ram_t;

    rsp_t rsp_q[$];
    ram_t ram_q[$];

    int tests = 0;
    int fails = 0;
    logic [31:0] last_load = 32'd0;
    bit   mon_off = 1'b0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned access_size(input logic [2:0] dt);
        if (dt == 3'd1 || dt == 3'd2) return 2;
        if (dt == 3'd3 || dt == 3'd4) return 1;
        return 4;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] dt, input logic [31:0] addr);
        return (addr % access_size(dt)) != 0;
    endfunction

    function automatic logic [3:0] model_we(input logic [2:0] dt, input logic [31:0] addr);
        int unsigned a = addr % 4;
        case (access_size(dt))
            1: return 4'(1 << a);
            2: return 4'(3 << (a - a % 2));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] dt, input logic [31:0] wd);
        case (access_size(dt))
            1: return (wd & 32'hFF) * 32'h01010101;
            2: return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] dt, input logic [31:0] addr, input logic [31:0] word);
        int unsigned a = addr % 4;
        int unsigned b = (word >> (8 * a)) & 32'hFF;
        int unsigned h = (word >> (16 * (a / 2))) & 32'hFFFF;
        case (dt)
            3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd2: return h;
            3'd3: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd4: return b;
            default: return word;
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT presents a response, exception or RAM request.
    bit   en_prev = 1'b0;
    int   en_len = 0;
    ram_t cur;
    bit   cause_pending = 1'b0;
    logic [7:0] cause_exp;

    always @(negedge clk) begin
        if (reset) begin
            en_prev = 1'b0;
            cause_pending = 1'b0;
        end else begin
            if (cause_pending) begin
                check("exc_cause", exc_cause == cause_exp, {24'b0, exc_cause}, {24'b0, cause_exp});
                cause_pending = 1'b0;
            end
            if (rsp_valid && exc_valid)
                check("rsp_and_exc_together", 1'b0, 32'd1, 32'd0);
            if (rsp_valid || exc_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_response", 1'b0, {31'b0, exc_valid}, 32'd0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("response_kind", exc_valid == e.is_exc, {31'b0, exc_valid}, {31'b0, e.is_exc});
                    if (rsp_valid && !e.is_exc)
                        check("rsp_rdata", rsp_rdata == e.rdata, rsp_rdata, e.rdata);
                    if (exc_valid && e.is_exc) begin
                        cause_pending = 1'b1;
                        cause_exp = e.cause;
                    end
                end
            end
            if (!mon_off) begin
                if (ram_en && !en_prev) begin
                    if (ram_q.size() == 0) begin
                        check("unexpected_ram_en", 1'b0, 32'd1, 32'd0);
                        cur = '{is_store: 1'b0, we: 4'h0, addr: '0, wdata: 32'd0, en_cycles: 0};
                    end else begin
                        cur = ram_q.pop_front();
                        check("ram_addr", ram_addr == cur.addr, 32'(ram_addr), 32'(cur.addr));
                        check("ram_we", ram_we == cur.we, 32'(ram_we), 32'(cur.we));
                        if (cur.is_store)
                            check("ram_wdata", ram_wdata == cur.wdata, ram_wdata, cur.wdata);
                    end
                    en_len = 0;
                end
                if (ram_en) en_len++;
                if (!ram_en && en_prev)
                    check("ram_en_cycles", en_len == cur.en_cycles, en_len, cur.en_cycles);
            end
            en_prev = ram_en;
        end
    end

    // Acts as the MEM stage and the RAM: holds the op while stalled, answers lat cycles after issue.
    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] dt, input int lat, input logic [31:0] word);
        rsp_t r;
        ram_t m;
        bit   mis, served;
        int   exp_stall, nstall, k;
        mis    = model_misaligned(dt, addr);
        served = (lat <= TIMEOUT + 1);
        r = '{is_exc: 1'b0, rdata: 32'd0, cause: 8'd0};
        if (mis) begin
            r.is_exc = 1'b1;
            r.cause  = wr ? 8'd6 : 8'd4;
            exp_stall = 0;
        end else begin
            m.is_store  = wr;
            m.we        = wr ? model_we(dt, addr) : 4'h0;
            m.addr      = ADDR_W'(addr >> 2);
            m.wdata     = model_wdata(dt, wd);
            m.en_cycles = (served ? lat : TIMEOUT + 1) + 1;
            ram_q.push_back(m);
            if (served) begin
                if (!wr) last_load = model_load(dt, addr, word);
                r.rdata = last_load;
            end else begin
                r.is_exc = 1'b1;
                r.cause  = wr ? 8'd7 : 8'd5;
            end
            exp_stall = m.en_cycles;
        end
        rsp_q.push_back(r);
        req_rd = !wr; req_wr = wr; req_addr = addr; req_wdata = wd; req_dmtype = dt;
        nstall = 0;
        k = 0;
        forever begin
            ram_ready = (k == lat) && !mis;
            ram_rdata = (k == lat) ? word : $urandom;
            #1;
            if (!stall) break;
            nstall++;
            k++;
            if (k > 60) begin
                check("op_cycle_budget", 1'b0, k, 60);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0; ram_ready = 1'b0;
        check("stall_cycles", nstall == exp_stall, nstall, exp_stall);
    endtask

    initial begin
        reset = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_dmtype = 3'd0;
        ram_ready = 1'b0; ram_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", stall == 1'b0, stall, 0);
        check("reset_ram_en", ram_en == 1'b0, ram_en, 0);
        check("reset_rsp_rdata", rsp_rdata == 32'd0, rsp_rdata, 0);
        check("reset_exc_cause", exc_cause == 8'd0, exc_cause, 0);
        check("reset_valids", {rsp_valid, exc_valid} == 2'b00, {rsp_valid, exc_valid}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(1'b1, 32'h101, 32'h123456AB, 3'd3, 2, 32'd0);
        do_op(1'b0, 32'h003, 32'd0, 3'd3, 1, 32'h80123456);
        do_op(1'b0, 32'h003, 32'd0, 3'd4, 1, 32'h80123456);
        do_op(1'b0, 32'h002, 32'd0, 3'd2, 1, 32'h80010000);
        do_op(1'b0, 32'h002, 32'd0, 3'd1, 1, 32'h80010000);
        do_op(1'b0, 32'h102, 32'd0, 3'd0, 1, 32'd0);
        do_op(1'b1, 32'h005, 32'h0000BEEF, 3'd1, 1, 32'd0);
        do_op(1'b0, 32'h010, 32'd0, 3'd0, 3, 32'hCAFEF00D);
        do_op(1'b1, 32'h020, 32'h11223344, 3'd7, 1, 32'd0);
        do_op(1'b0, 32'h030, 32'd0, 3'd0, NEVER, 32'd0);
        do_op(1'b1, 32'h034, 32'h55667788, 3'd0, NEVER, 32'd0);
        do_op(1'b0, 32'h038, 32'd0, 3'd0, TIMEOUT + 1, 32'h0BADCAFE);
        do_op(1'b0, 32'h03C, 32'd0, 3'd0, TIMEOUT + 2, 32'h0BADCAFE);

        for (int i = 0; i < 150; i++) begin
            int lat;
            int sel;
            sel = $urandom_range(0, 19);
            lat = (sel == 0) ? NEVER : (sel == 1) ? TIMEOUT + 1 : $urandom_range(1, 4);
            do_op(1'($urandom_range(0, 1)), $urandom & 32'h0000FFFF, $urandom,
                  3'($urandom_range(0, 7)), lat, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Reset while the unit waits on a RAM that never answers, with the request still held.
        mon_off = 1'b1;
        req_rd = 1'b1; req_addr = 32'h040; req_dmtype = 3'd0; ram_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_wait_ram_en", ram_en == 1'b0, ram_en, 0);
        check("reset_wait_stall", stall == 1'b0, stall, 0);
        @(posedge clk); #1;
        req_rd = 1'b0;
        reset = 1'b0;
        check("reset_wait_rdata", rsp_rdata == 32'd0, rsp_rdata, 0);
        last_load = 32'd0;
        @(posedge clk); #1;
        mon_off = 1'b0;
        do_op(1'b0, 32'h044, 32'd0, 3'd0, 2, 32'h76543210);
        do_op(1'b1, 32'h046, 32'h0000A5A5, 3'd2, 1, 32'd0);

        repeat (3) @(posedge clk);
        check("rsp_queue_drained", rsp_q.size() == 0, rsp_q.size(), 0);
        check("ram_queue_drained", ram_q.size() == 0, ram_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
